// File: rtl/present_key_scheduler_pkg.sv
// Shared widths, FSM state encoding and the 4-bit S-box for the toy-PRESENT key schedule.
package present_pkg;

  localparam int KEY_W = 20;
  localparam int RK_W  = 16;
  localparam int IDX_W = 6;

  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    FILL,
    EMIT_REV
  } state_t;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      default: y = 4'h2;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/present_key_scheduler_if.sv
// Key-load and round-key channels of the key scheduler; dec_mode exists only with KSCHED_REVERSE_EN.
interface present_key_scheduler_if;
  import present_pkg::*;

  logic [KEY_W-1:0] key_in;
  logic             key_valid;
  logic             key_ready;
  logic [RK_W-1:0]  rk;
  logic [IDX_W-1:0] rk_idx;
  logic             rk_valid;
  logic             rk_ready;
  logic             rk_last;
  logic             busy;
`ifdef KSCHED_REVERSE_EN
  logic             dec_mode;
`endif

  modport master (
`ifdef KSCHED_REVERSE_EN
    output dec_mode,
`endif
    output key_in, key_valid, rk_ready,
    input  key_ready, rk, rk_idx, rk_valid, rk_last, busy
  );

  modport slave (
`ifdef KSCHED_REVERSE_EN
    input  dec_mode,
`endif
    input  key_in, key_valid, rk_ready,
    output key_ready, rk, rk_idx, rk_valid, rk_last, busy
  );

endinterface

// File: rtl/present_key_scheduler_key_update.sv
// One combinational key-update step: rotate left 13, S-box the top nibble, fold the round LSB into bits [7:4].
module key_update
  import present_pkg::*;
(
  input  logic [KEY_W-1:0] key,
  input  logic             round_count_lsb,
  output logic [KEY_W-1:0] key_next
);

  logic [KEY_W-1:0] rot;

  assign rot      = {key[6:0], key[19:7]};
  assign key_next = {sbox(rot[19:16]), rot[15:8], rot[7:4] ^ {4{round_count_lsb}}, rot[3:0]};

endmodule

// File: rtl/present_key_scheduler.sv
// Round-key sequencer for toy-PRESENT; KSCHED_REVERSE_EN adds a buffered reverse (decryption) order.
//
// state    | meaning
// IDLE     | waiting for a master key, key_ready high
// EMIT     | presenting key_reg[19:4] as round key idx, advancing on each handshake
// FILL     | reverse mode: writing every round key into the buffer, no output
// EMIT_REV | reverse mode: replaying the buffer from idx NUM_ROUNDS+1 down to 1
module present_key_scheduler
  import present_pkg::*;
#(
  parameter int NUM_ROUNDS = 31
) (
  input  logic                    clk,
  input  logic                    rst_n,
  present_key_scheduler_if.slave  ks
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROUNDS + 1);
  localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

  state_t           state, state_nx;
  logic [KEY_W-1:0] key_reg, key_nx, key_upd;
  logic [IDX_W-1:0] idx, idx_nx;
  logic             at_last;
  logic [RK_W-1:0]  rk_cur;
  logic             rk_last_cur;

  key_update u_key_update (
    .key             (key_reg),
    .round_count_lsb (idx[0]),
    .key_next        (key_upd)
  );

  assign at_last = (idx == LAST_IDX);

`ifdef KSCHED_REVERSE_EN
  localparam int BUF_AW = $clog2(NUM_ROUNDS + 1);

  logic [RK_W-1:0]   rk_buf [0:NUM_ROUNDS];
  logic [BUF_AW-1:0] buf_addr;

  // Entry i-1 holds round key i so the buffer is exactly NUM_ROUNDS+1 deep.
  assign buf_addr = BUF_AW'(idx - ONE_IDX);

  always_ff @(posedge clk) begin
    if (state == FILL) begin
      rk_buf[buf_addr] <= key_reg[19:4];
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      key_reg <= '0;
      idx     <= '0;
    end else begin
      state   <= state_nx;
      key_reg <= key_nx;
      idx     <= idx_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    key_nx      = key_reg;
    idx_nx      = idx;
    rk_cur      = '0;
    rk_last_cur = 1'b0;
    case (state)
      IDLE: begin
        if (ks.key_valid) begin
          key_nx = ks.key_in;
          idx_nx = ONE_IDX;
`ifdef KSCHED_REVERSE_EN
          state_nx = ks.dec_mode ? FILL : EMIT;
`else
          state_nx = EMIT;
`endif
        end
      end
      EMIT: begin
        rk_cur      = key_reg[19:4];
        rk_last_cur = at_last;
        if (ks.rk_ready) begin
          if (at_last) begin
            state_nx = IDLE;
          end else begin
            key_nx = key_upd;
            idx_nx = idx + ONE_IDX;
          end
        end
      end
`ifdef KSCHED_REVERSE_EN
      FILL: begin
        if (at_last) begin
          state_nx = EMIT_REV;
        end else begin
          key_nx = key_upd;
          idx_nx = idx + ONE_IDX;
        end
      end
      EMIT_REV: begin
        rk_cur      = rk_buf[buf_addr];
        rk_last_cur = (idx == ONE_IDX);
        if (ks.rk_ready) begin
          if (idx == ONE_IDX) begin
            state_nx = IDLE;
          end else begin
            idx_nx = idx - ONE_IDX;
          end
        end
      end
`endif
      default: state_nx = IDLE;
    endcase
  end

  assign ks.key_ready = (state == IDLE);
  assign ks.busy      = (state != IDLE);
  assign ks.rk_valid  = (state == EMIT) || (state == EMIT_REV);
  assign ks.rk        = rk_cur;
  assign ks.rk_idx    = ks.rk_valid ? idx : '0;
  assign ks.rk_last   = rk_last_cur;

endmodule

// File: tb/tb_present_key_scheduler.sv
// Scoreboard bench for present_key_scheduler (NUM_ROUNDS=31 and NUM_ROUNDS=1 instances).
module tb_present_key_scheduler;

  typedef struct packed {
    logic [15:0] rk;
    logic [5:0]  idx;
    logic        last;
  } exp_t;

  logic clk;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;
  bit   rnd_ready = 0;
  exp_t q0[$];
  exp_t q1[$];
  int   sbox_t [16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};

  present_key_scheduler_if if0 ();
  present_key_scheduler_if if1 ();

  present_key_scheduler #(.NUM_ROUNDS(31)) dut (.clk(clk), .rst_n(rst_n), .ks(if0));
  present_key_scheduler #(.NUM_ROUNDS(1))  dut1 (.clk(clk), .rst_n(rst_n), .ks(if1));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Reference: the key schedule written as plain integer arithmetic.
  function automatic logic [19:0] ref_step(input logic [19:0] k, input int r);
    int unsigned v;
    int unsigned s;
    v = {12'd0, k};
    v = ((v << 13) | (v >> 7)) & 32'h000F_FFFF;
    s = sbox_t[v[19:16]];
    v = (v & 32'h0000_FFFF) | (s << 16);
    if (r % 2 == 1) v = v ^ 32'h0000_00F0;
    return v[19:0];
  endfunction

  function automatic logic [15:0] ref_rk(input logic [19:0] key, input int i);
    logic [19:0] k;
    k = key;
    for (int j = 1; j < i; j++) k = ref_step(k, j);
    return k[19:4];
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic push_exp(input int dut_sel, input logic [19:0] key, input int n, input bit rev);
    exp_t e;
    for (int s = 1; s <= n + 1; s++) begin
      int i;
      i = rev ? (n + 2 - s) : s;
      e.rk   = ref_rk(key, i);
      e.idx  = 6'(i);
      e.last = rev ? (i == 1) : (i == n + 1);
      if (dut_sel == 0) q0.push_back(e);
      else q1.push_back(e);
    end
  endtask

  // Monitor: every accepted round key must match the head of the expected queue.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (if0.rk_valid && if0.rk_ready) begin
        if (q0.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb0_unexpected got idx=%0d rk=%0h expected=none", if0.rk_idx, if0.rk);
        end else begin
          e = q0.pop_front();
          check("sb0_rk", {16'd0, if0.rk}, {16'd0, e.rk});
          check("sb0_idx", {26'd0, if0.rk_idx}, {26'd0, e.idx});
          check("sb0_last", {31'd0, if0.rk_last}, {31'd0, e.last});
        end
      end
      if (if1.rk_valid && if1.rk_ready) begin
        if (q1.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb1_unexpected got idx=%0d rk=%0h expected=none", if1.rk_idx, if1.rk);
        end else begin
          e = q1.pop_front();
          check("sb1_rk", {16'd0, if1.rk}, {16'd0, e.rk});
          check("sb1_idx", {26'd0, if1.rk_idx}, {26'd0, e.idx});
          check("sb1_last", {31'd0, if1.rk_last}, {31'd0, e.last});
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_ready) if0.rk_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic load0(input logic [19:0] k, input bit dm);
    int n;
    n = 0;
    while (!if0.key_ready && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("load0_wait", {31'd0, n < 3000}, 32'd1);
    if0.key_in    = k;
    if0.key_valid = 1'b1;
`ifdef KSCHED_REVERSE_EN
    if0.dec_mode  = dm;
`endif
    push_exp(0, k, 31, dm);
    @(posedge clk);
    #1;
    if0.key_valid = 1'b0;
  endtask

  task automatic wait_idle0();
    int n;
    n = 0;
    while ((if0.busy || q0.size() != 0) && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain0_timeout", {31'd0, n < 3000}, 32'd1);
  endtask

  task automatic wait_idx0(input logic [5:0] target);
    int n;
    n = 0;
    while (if0.rk_idx != target && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("wait_idx_timeout", {31'd0, n < 200}, 32'd1);
  endtask

  initial begin
    logic [19:0] key;
    if0.key_in = '0; if0.key_valid = 0; if0.rk_ready = 0;
    if1.key_in = '0; if1.key_valid = 0; if1.rk_ready = 0;
`ifdef KSCHED_REVERSE_EN
    if0.dec_mode = 0;
    if1.dec_mode = 0;
`endif
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    check("rst_rk_valid", {31'd0, if0.rk_valid}, 32'd0);
    check("rst_busy", {31'd0, if0.busy}, 32'd0);
    check("rst_key_ready", {31'd0, if0.key_ready}, 32'd1);
    check("rst_rk", {16'd0, if0.rk}, 32'd0);
    check("rst_rk_idx", {26'd0, if0.rk_idx}, 32'd0);
    check("rst_rk_last", {31'd0, if0.rk_last}, 32'd0);

    // Zero key, full-rate consumer.
    if0.rk_ready = 1;
    load0(20'h00000, 0);
    check("first_latency_valid", {31'd0, if0.rk_valid}, 32'd1);
    check("first_rk", {16'd0, if0.rk}, 32'h0000);
    check("first_idx", {26'd0, if0.rk_idx}, 32'd1);
    @(posedge clk);
    #1;
    check("second_rk", {16'd0, if0.rk}, 32'hC00F);
    check("second_idx", {26'd0, if0.rk_idx}, 32'd2);
    wait_idle0();
    check("key_ready_after", {31'd0, if0.key_ready}, 32'd1);

    // Back-pressure at idx 3.
    load0(20'hFFFFF, 0);
    wait_idx0(6'd3);
    if0.rk_ready = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      check("stall_valid", {31'd0, if0.rk_valid}, 32'd1);
      check("stall_idx", {26'd0, if0.rk_idx}, 32'd3);
      check("stall_rk", {16'd0, if0.rk}, {16'd0, ref_rk(20'hFFFFF, 3)});
    end
    if0.rk_ready = 1;
    wait_idle0();

    // A second key offered while busy must be ignored.
    rnd_ready = 1;
    load0(20'($urandom), 0);
    repeat (10) begin
      if0.key_in    = 20'($urandom);
      if0.key_valid = 1'b1;
      @(posedge clk);
      #1;
      check("busy_key_ready", {31'd0, if0.key_ready}, 32'd0);
    end
    if0.key_valid = 1'b0;
    wait_idle0();

    // Reset in the middle of a sequence.
    rnd_ready = 0;
    if0.rk_ready = 1;
    load0(20'($urandom), 0);
    wait_idx0(6'd10);
    rst_n = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    q0.delete();
    check("midrst_rk_valid", {31'd0, if0.rk_valid}, 32'd0);
    check("midrst_busy", {31'd0, if0.busy}, 32'd0);
    check("midrst_key_ready", {31'd0, if0.key_ready}, 32'd1);
    load0(20'($urandom), 0);
    check("restart_idx", {26'd0, if0.rk_idx}, 32'd1);
    wait_idle0();

    // Randomized keys and consumer stalls.
    rnd_ready = 1;
    for (int t = 0; t < 6; t++) begin
      key = 20'($urandom);
`ifdef KSCHED_REVERSE_EN
      load0(key, 1'($urandom_range(0, 1)));
`else
      load0(key, 0);
`endif
      wait_idle0();
    end
    rnd_ready = 0;
    if0.rk_ready = 1;

    // Two-key schedule (NUM_ROUNDS=1).
    if1.rk_ready = 1;
    key = 20'($urandom);
    push_exp(1, key, 1, 0);
    if1.key_in = key;
    if1.key_valid = 1;
    @(posedge clk);
    #1;
    if1.key_valid = 0;
    check("n1_valid1", {31'd0, if1.rk_valid}, 32'd1);
    check("n1_idx1", {26'd0, if1.rk_idx}, 32'd1);
    check("n1_last1", {31'd0, if1.rk_last}, 32'd0);
    @(posedge clk);
    #1;
    check("n1_idx2", {26'd0, if1.rk_idx}, 32'd2);
    check("n1_last2", {31'd0, if1.rk_last}, 32'd1);
    @(posedge clk);
    #1;
    check("n1_done_valid", {31'd0, if1.rk_valid}, 32'd0);
    check("n1_done_ready", {31'd0, if1.key_ready}, 32'd1);
    check("n1_queue_empty", q1.size(), 32'd0);

`ifdef KSCHED_REVERSE_EN
    // Reverse order: 32 fill cycles with no output, then keys 32..1.
    begin
      int n;
      rnd_ready = 1;
      load0(20'h00000, 1);
      n = 0;
      while (!if0.rk_valid && n < 200) begin
        check("fill_busy", {31'd0, if0.busy}, 32'd1);
        @(posedge clk);
        #1;
        n++;
      end
      // Sampling starts one cycle after the load edge, so 33 cycles of latency show as 32 here.
      check("rev_latency", n, 32'd32);
      check("rev_first_idx", {26'd0, if0.rk_idx}, 32'd32);
      wait_idle0();
      rnd_ready = 0;
      if0.rk_ready = 1;
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/present_key_scheduler.md
Name: present_key_scheduler

Overview:
- Sequencer for the 20-bit toy-PRESENT key schedule.
- Accepts a master key via valid/ready and iterates the combinational key-update step once per accepted round key.
- Streams 16-bit round keys K1..K(NUM_ROUNDS+1) to the round datapath over a valid/ready interface, with round index and last flag.
- Sits between the key loader and the encryption round engine; owns the round counter that drives the update step's round_count_lsb.

Parameters:
- NUM_ROUNDS, 31, number of cipher rounds; NUM_ROUNDS+1 round keys emitted; legal range 1..62.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset; one clock; reset is synchronous and active-low
- key_in  input  20  master key
- key_valid  input  1  key_in valid
- key_ready  output  1  high only in IDLE; load occurs on key_valid & key_ready
- rk  output  16  current round key = key_reg[19:4]
- rk_idx  output  6  round-key index, 1..NUM_ROUNDS+1
- rk_valid  output  1  rk/rk_idx/rk_last valid
- rk_ready  input  1  consumer accepts rk
- rk_last  output  1  high with the final round key of the sequence
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst_n=0 at an edge): state IDLE, key_reg=0, idx=0, rk_valid=0, rk=0, rk_idx=0, rk_last=0, busy=0; key_ready=1 from the first cycle after reset. Reset mid-sequence abandons it; no further rk_valid.
- IDLE: on key_valid & key_ready: key_reg<=key_in, idx<=1, go EMIT. Otherwise hold.
- EMIT: rk_valid=1, rk=key_reg[19:4], rk_idx=idx. rk_valid is high the cycle after the load handshake, so first-key latency is 1 cycle. Outputs hold stable while rk_ready=0.
- EMIT handshake (rk_valid & rk_ready):
  - if idx==NUM_ROUNDS+1: go IDLE; rk_valid=0 next cycle.
  - else: key_reg<=update(key_reg, idx[0]), idx<=idx+1; stay EMIT. Throughput is one key per cycle when rk_ready is held high.
- update(k,b): rotate k left by 13 ({k[6:0],k[19:7]}); apply S-box to bits [19:16]; XOR bits [7:4] with b.
- rk_last = rk_valid & (idx==NUM_ROUNDS+1).
- key_valid is ignored whenever key_ready=0; no queuing.
- rk_ready while rk_valid=0 has no effect.
- idx never wraps; the 6-bit width covers a maximum of 63.

Optional Feature:
- Macro: KSCHED_REVERSE_EN.
- Defined:
  - Adds input port dec_mode (1 bit), sampled with the key load.
  - Adds a NUM_ROUNDS+1 x 16 round-key buffer.
  - dec_mode=0: behaviour identical to forward mode.
  - dec_mode=1:
    - FILL state: each cycle writes buf[idx]=key_reg[19:4]. If idx<NUM_ROUNDS+1, apply update and increment idx; at idx==NUM_ROUNDS+1, write and go EMIT_REV.
    - rk_valid=0 and busy=1 throughout FILL; rk_ready is ignored.
    - EMIT_REV: emits buf[idx] with rk_idx=idx, decrementing idx on each handshake. rk_last when idx==1; handshake at idx==1 goes to IDLE.
    - First rk_valid occurs NUM_ROUNDS+2 cycles after the load handshake.
- Undefined: no dec_mode port, no buffer, forward only.

Decomposition:
- Shared package present_pkg:
  - KEY_W=20, RK_W=16, IDX_W=6
  - state enum {IDLE, EMIT, FILL, EMIT_REV}
  - the 4-bit S-box table (S(0)=0xC)
- Sub-module: existing key_update instance for the update step; no other sub-modules.

Test Plan:
- Reset then load key 0x00000 with rk_ready=1 -> rk_valid next cycle: rk=0x0000, idx=1; following cycle rk=0xC00F, idx=2; rk_last only at idx=32; key_ready=1 after.
- Load 0xFFFFF, hold rk_ready=0 for 5 cycles at idx=3 -> rk/rk_idx stable, rk_valid=1, idx does not advance; release resumes at idx=3.
- key_valid=1 with a different key during EMIT -> ignored (key_ready=0); sequence unchanged; full 32-key stream matches golden model.
- rst_n=0 at idx=10 -> next cycle rk_valid=0, busy=0, key_ready=1; new load restarts at idx=1.
- NUM_ROUNDS=1 -> exactly 2 keys, rk_last on idx=2, then IDLE.
- KSCHED_REVERSE_EN, dec_mode=1, key 0x00000 -> first rk_valid 33 cycles after load: idx=32; stream idx 32..1 equals the forward stream reversed; rk_last at idx=1 with rk=0x0000.
